baser_257b_flow_distributor: RTL
================================

Name: baser_257b_flow_distributor

Overview:
- Sits directly downstream of the PCS generator's 257b transcoder output, on the TX path ahead of the FEC stage.
- Receives a stream of 257-bit transcoded blocks under a valid/ready handshake.
- Distributes blocks round-robin into two flows: even-numbered to flow 0, odd-numbered to flow 1.
- Scrambles each flow with its own self-synchronous scrambler and presents each flow-0/flow-1 pair together on a registered output.

Parameters:
- TC_WIDTH, 257, width of one transcoded block (1b header + 256b payload).
- SCR_WIDTH, 58, scrambler state width.
- SCR_SEED, 58'h3FF_FFFF_FFFF_FFFF, reset value of both scrambler states.
- CNT_WIDTH, 32, width of the pair counter.

Ports:
- clk  in  1  single clock.
- i_rst  in  1  asynchronous active-high reset.
- i_tc_block  in  TC_WIDTH  input transcoded block.
- i_tc_valid  in  1  input block valid.
- o_tc_ready  out  1  block accepted when i_tc_valid & o_tc_ready.
- i_scr_bypass  in  1  1 = pass data unscrambled; scrambler states frozen.
- i_clear  in  1  synchronous: drop held half-pair, next accepted block goes to flow 0.
- o_flow_0  out  TC_WIDTH  scrambled flow-0 block.
- o_flow_1  out  TC_WIDTH  scrambled flow-1 block.
- o_valid  out  1  pair valid.
- i_ready  in  1  downstream accepts the pair when o_valid & i_ready.
- o_pair_count  out  CNT_WIDTH  number of pairs delivered downstream.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous, active-high (i_rst).
- Reset values:
  - o_flow_0, o_flow_1 = 0; o_valid = 0; o_pair_count = 0.
  - Both scrambler states = SCR_SEED; internal state = EMPTY; hold register = 0.
- o_tc_ready = !o_valid | i_ready. Combinational from the output register state, so a pair and a new input can transfer in the same cycle.
- State machine:
  - EMPTY: on accept, scramble the block with scr0, store it in the hold register, go to HALF.
  - HALF: on accept, scramble the block with scr1. Load o_flow_0 = hold and o_flow_1 = scrambled block; set o_valid = 1; go to EMPTY.
  - A pair transfers when o_valid & i_ready. o_valid clears unless a new pair is loaded in the same cycle, in which case it stays 1. o_pair_count increments, wrapping modulo 2^CNT_WIDTH.
- Latency: o_valid rises the cycle after the odd (second) block of a pair is accepted.
- Scrambler: polynomial 1 + x^39 + x^58, applied over all TC_WIDTH bits, bit 0 first. Per bit k:
  - s = d[k] ^ S[38] ^ S[57]
  - S <= {S[56:0], s}
  - out[k] = s
  - Implemented as a 257-step unrolled combinational loop. The state register updates only on an accepted block of its own flow.
- i_scr_bypass: sampled per accepted block. Output = input; that flow's scrambler state is unchanged.
- i_clear:
  - Forces the state to EMPTY and discards the held block.
  - Scrambler states and the output register are unaffected.
  - If i_clear and an accept occur in the same cycle, the accepted block is treated as a flow-0 block (clear wins over the held half).
- Backpressure: while o_valid & !i_ready, o_tc_ready = 0. In that condition the hold register and scrambler states do not change, and o_flow_x / o_valid are held stable.
- Asynchronous reset mid-pair drops the held block and restores the seeds; the first post-reset block goes to flow 0.

Decomposition:
- Shared package (baser_pkg), add:
  - TC_WIDTH and SCR_WIDTH constants.
  - The scrambler tap positions (39, 58).
  - The flow-state enum {EMPTY, HALF}.
- One natural sub-module: baser_257b_scrambler. It is purely combinational (data in, state in → scrambled data out, next state out), is instantiated twice, and is reusable by a matching descrambler in the checker path.

Test Plan:
- Pairing (bypass, continuous valid, i_ready = 1): send A = {257{1'b1}}, then B = 257'h0_AAAA…AAAA. Expect o_flow_0 = A and o_flow_1 = B one cycle after B is accepted; o_pair_count = 1.
- Scrambler impulse (SCR_SEED = 0, scrambling on): send all-zero, then all-zero. Both flows must be 0. Next pair: flow-0 block with only bit 0 set. Expect o_flow_0 bits 0, 39, 58 = 1 and bits 1–38 = 0.
- Backpressure: hold i_ready = 0 with a pair pending and keep driving valid blocks. o_tc_ready must be 0 and outputs stable for 10 cycles. Release i_ready: pair taken, the next block accepted in the same cycle, and no block lost or duplicated across 8 pairs.
- i_clear: send block C (HALF), then assert i_clear together with block D. Expect the next pair to be o_flow_0 = D (scrambled) and C never output.
- Round trip: 100 random blocks through the block plus a reference descrambler per flow (same seed). The reconstructed stream must equal the input in order; o_pair_count = 50.
- Async reset mid-pair: assert i_rst while in HALF. Outputs go to 0 immediately; the next two blocks pair as flow 0 / flow 1 with seeds restored.

Source files
------------

// File: rtl/baser_257b_flow_distributor_pkg.sv
// ----------------------------------------------------------------------------
// baser_257b_flow_distributor_pkg
// Shared constants and types for the 257b flow distributor and its scrambler.
//   TC_WIDTH            width of one transcoded block (1b header + 256b payload)
//   SCR_WIDTH           self-synchronous scrambler state width
//   SCR_TAP_A/SCR_TAP_B polynomial taps of 1 + x^39 + x^58
//   CNT_WIDTH           width of the delivered-pair counter
//   flow_state_e        EMPTY = no half-pair held, HALF = flow-0 block held
// ----------------------------------------------------------------------------
package baser_257b_flow_distributor_pkg;

   localparam int TC_WIDTH  = 257;
   localparam int SCR_WIDTH = 58;
   localparam int SCR_TAP_A = 39;
   localparam int SCR_TAP_B = 58;
   localparam int CNT_WIDTH = 32;

   localparam logic [SCR_WIDTH-1:0] SCR_SEED_DEFAULT = 58'h3FF_FFFF_FFFF_FFFF;

   typedef logic [TC_WIDTH-1:0]  tc_block_t;
   typedef logic [SCR_WIDTH-1:0] scr_state_t;
   typedef logic [CNT_WIDTH-1:0] pair_count_t;

   typedef enum logic {
      EMPTY = 1'b0,
      HALF  = 1'b1
   } flow_state_e;

endpackage

// File: rtl/baser_257b_flow_distributor_if.sv
// ----------------------------------------------------------------------------
// baser_257b_flow_distributor_if
// Groups the input block stream, the control strobes and the paired output
// stream of the flow distributor. Signal names carry the direction as seen
// from the distributor (i_ = into it, o_ = out of it).
//   slave  : view used by the distributor itself
//   master : view used by whatever feeds and drains it
// ----------------------------------------------------------------------------
interface baser_257b_flow_distributor_if;
   import baser_257b_flow_distributor_pkg::*;

   tc_block_t   i_tc_block;
   logic        i_tc_valid;
   logic        o_tc_ready;
   logic        i_scr_bypass;
   logic        i_clear;
   tc_block_t   o_flow_0;
   tc_block_t   o_flow_1;
   logic        o_valid;
   logic        i_ready;
   pair_count_t o_pair_count;

   modport slave (
      input  i_tc_block, i_tc_valid, i_scr_bypass, i_clear, i_ready,
      output o_tc_ready, o_flow_0, o_flow_1, o_valid, o_pair_count
   );

   modport master (
      output i_tc_block, i_tc_valid, i_scr_bypass, i_clear, i_ready,
      input  o_tc_ready, o_flow_0, o_flow_1, o_valid, o_pair_count
   );

endinterface

// File: rtl/baser_257b_scrambler.sv
// ----------------------------------------------------------------------------
// baser_257b_scrambler
// Purely combinational self-synchronous scrambler, 1 + x^39 + x^58, applied
// over one whole block, bit 0 first.
//   data_in   block to scramble
//   state_in  scrambler state before this block
//   data_out  scrambled block
//   state_out scrambler state after this block (caller decides whether to keep)
// ----------------------------------------------------------------------------
module baser_257b_scrambler
   import baser_257b_flow_distributor_pkg::*;
(
   input  tc_block_t  data_in,
   input  scr_state_t state_in,
   output tc_block_t  data_out,
   output scr_state_t state_out
);

   scr_state_t shift;
   logic       fb;

   // Unrolled per-bit scrambling: each output bit is fed straight back into
   // the shift register, which is what makes the descrambler self-synchronising.
   always_comb begin
      shift    = state_in;
      fb       = 1'b0;
      data_out = '0;
      for (int k = 0; k < TC_WIDTH; k++) begin
         fb          = data_in[k] ^ shift[SCR_TAP_A-1] ^ shift[SCR_TAP_B-1];
         data_out[k] = fb;
         shift       = {shift[SCR_WIDTH-2:0], fb};
      end
      state_out = shift;
   end

endmodule

// File: rtl/baser_257b_flow_distributor.sv
// ----------------------------------------------------------------------------
// baser_257b_flow_distributor
// Splits a 257b transcoded block stream round-robin into two flows (even
// blocks to flow 0, odd to flow 1), scrambles each flow with its own
// scrambler and presents each flow-0/flow-1 pair on a registered output.
//   clk    single clock
//   i_rst  asynchronous active-high reset
//   bus    input stream (i_tc_*), bypass/clear strobes, paired output stream
//          (o_flow_0/1, o_valid, i_ready) and the delivered-pair counter
// ----------------------------------------------------------------------------
module baser_257b_flow_distributor
   import baser_257b_flow_distributor_pkg::*;
#(
   parameter scr_state_t SCR_SEED = SCR_SEED_DEFAULT
)(
   input  logic                          clk,
   input  logic                          i_rst,
   baser_257b_flow_distributor_if.slave  bus
);

   flow_state_e state_q, state_d;
   tc_block_t   hold_q, hold_d;
   tc_block_t   flow_0_q, flow_0_d;
   tc_block_t   flow_1_q, flow_1_d;
   logic        valid_q, valid_d;
   pair_count_t count_q, count_d;
   scr_state_t  scr0_q, scr0_d;
   scr_state_t  scr1_q, scr1_d;

   tc_block_t   scr0_data, scr1_data;
   scr_state_t  scr0_next, scr1_next;
   logic        tc_ready;
   logic        accept;
   logic        take_pair;
   logic        to_flow_0;

   // The input may be taken whenever the output register is empty or is being
   // drained this cycle, so a pair leaves and a new block arrives together.
   // A clear on the same cycle as an accept redirects that block to flow 0.
   assign tc_ready  = !valid_q | bus.i_ready;
   assign accept    = bus.i_tc_valid & tc_ready;
   assign take_pair = valid_q & bus.i_ready;
   assign to_flow_0 = bus.i_clear | (state_q == EMPTY);

   baser_257b_scrambler u_scr0 (
      .data_in   (bus.i_tc_block),
      .state_in  (scr0_q),
      .data_out  (scr0_data),
      .state_out (scr0_next)
   );

   baser_257b_scrambler u_scr1 (
      .data_in   (bus.i_tc_block),
      .state_in  (scr1_q),
      .data_out  (scr1_data),
      .state_out (scr1_next)
   );

   // State register for the pairing FSM and all datapath registers.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= EMPTY;
         hold_q   <= '0;
         flow_0_q <= '0;
         flow_1_q <= '0;
         valid_q  <= 1'b0;
         count_q  <= '0;
         scr0_q   <= SCR_SEED;
         scr1_q   <= SCR_SEED;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         flow_0_q <= flow_0_d;
         flow_1_q <= flow_1_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
         scr0_q   <= scr0_d;
         scr1_q   <= scr1_d;
      end
   end

   // Next-state logic: every accepted block toggles between the two halves of
   // a pair; a clear without an accept simply abandons the held half.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = to_flow_0 ? HALF : EMPTY;
      end else if (bus.i_clear) begin
         state_d = EMPTY;
      end
   end

   // Output/datapath logic: a flow-0 block is parked in the hold register, a
   // flow-1 block completes the pair and loads the output register. Scrambler
   // states advance only for their own flow and only when not bypassed.
   always_comb begin
      hold_d   = hold_q;
      flow_0_d = flow_0_q;
      flow_1_d = flow_1_q;
      valid_d  = valid_q;
      count_d  = count_q;
      scr0_d   = scr0_q;
      scr1_d   = scr1_q;

      if (bus.i_clear) begin
         hold_d = '0;
      end

      if (accept && to_flow_0) begin
         hold_d = bus.i_scr_bypass ? bus.i_tc_block : scr0_data;
         if (!bus.i_scr_bypass) begin
            scr0_d = scr0_next;
         end
      end

      if (accept && !to_flow_0) begin
         flow_0_d = hold_q;
         flow_1_d = bus.i_scr_bypass ? bus.i_tc_block : scr1_data;
         valid_d  = 1'b1;
         if (!bus.i_scr_bypass) begin
            scr1_d = scr1_next;
         end
      end else if (take_pair) begin
         valid_d = 1'b0;
      end

      if (take_pair) begin
         count_d = count_q + pair_count_t'(1);
      end
   end

   assign bus.o_tc_ready   = tc_ready;
   assign bus.o_flow_0     = flow_0_q;
   assign bus.o_flow_1     = flow_1_q;
   assign bus.o_valid      = valid_q;
   assign bus.o_pair_count = count_q;

endmodule
